cmp_arbiter: RTL and testbench

Shared-comparator controller for the integer pipeline: arbitrates a single WORDSIZE-bit compare datapath between the branch path (requester 0) and the SLT/SLTU path (requester 1). Accepts one compare request at a time over a valid/ready handshake, evaluates the RISC-V funct3 condition on registered operands, and returns a one-bit result, tagged with the requester id, over a valid/ready response channel. Sits between decode/issue and the branch-resolution and writeback logic.

---
 rtl/cmp_arbiter_pkg.sv | 43 ++++
 rtl/cmp_arbiter_if.sv | 39 +++
 rtl/cmp_arbiter_flags.sv | 17 +
 rtl/cmp_arbiter.sv | 136 +++++++++++++
 tb/tb_cmp_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/cmp_arbiter_pkg.sv
// Shared definitions for the compare arbiter: funct3 codes, FSM states,
// requester ids and the condition-select helper.
package cmp_arbiter_pkg;

    localparam int WORDSIZE_DEF = 64;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] SLT  = 3'b010;
    localparam logic [2:0] SLTU = 3'b011;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam logic REQ_ID_0 = 1'b0;
    localparam logic REQ_ID_1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Select the condition outcome for a funct3 code from the three raw flags.
    function automatic logic cond_eval(input logic [2:0] f3, input logic eq,
                                       input logic lt, input logic ltu);
        logic res;
        case (f3)
            BEQ:     res = eq;
            BNE:     res = ~eq;
            SLT:     res = lt;
            SLTU:    res = ltu;
            BLT:     res = lt;
            BGE:     res = ~lt;
            BLTU:    res = ltu;
            BGEU:    res = ~ltu;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between the two compare requesters and the arbiter.
interface cmp_arbiter_if #(parameter int WORDSIZE = 64);

    logic                req0_valid;
    logic                req0_ready;
    logic [WORDSIZE-1:0] req0_a;
    logic [WORDSIZE-1:0] req0_b;
    logic [2:0]          req0_funct3;

    logic                req1_valid;
    logic                req1_ready;
    logic [WORDSIZE-1:0] req1_a;
    logic [WORDSIZE-1:0] req1_b;
    logic [2:0]          req1_funct3;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic                rsp_result;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_funct3,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_funct3,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_funct3,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_funct3,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result,
        output rsp_ready
    );

endinterface

// File: rtl/cmp_arbiter_flags.sv
// Raw comparison flags (equal, signed less-than, unsigned less-than) over
// two full-width operands.
module cmp_flags #(
    parameter int WORDSIZE = 64
) (
    input  logic [WORDSIZE-1:0] a_i,
    input  logic [WORDSIZE-1:0] b_i,
    output logic                eq_o,
    output logic                lt_o,
    output logic                ltu_o
);

    assign eq_o  = (a_i == b_i);
    assign lt_o  = ($signed(a_i) < $signed(b_i));
    assign ltu_o = (a_i < b_i);

endmodule

// File: rtl/cmp_arbiter.sv
// Shares one compare datapath between the branch path (requester 0) and the
// SLT path (requester 1); one request in flight, result returned tagged by id.
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter int WORDSIZE = WORDSIZE_DEF
) (
    input  logic          clk,
    input  logic          reset,
    cmp_arbiter_if.slave  bus
);

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [WORDSIZE-1:0] a_q, a_d;
    logic [WORDSIZE-1:0] b_q, b_d;
    logic [2:0]          f3_q, f3_d;
    logic                id_q, id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic                rsp_result_q, rsp_result_d;

    logic                grant_s;
    logic                any_valid_s;
    logic                ready0_s, ready1_s;
    logic                eq_s, lt_s, ltu_s;

    cmp_flags #(.WORDSIZE(WORDSIZE)) u_flags (
        .a_i   (a_q),
        .b_i   (b_q),
        .eq_o  (eq_s),
        .lt_o  (lt_s),
        .ltu_o (ltu_s)
    );

    assign any_valid_s = bus.req0_valid | bus.req1_valid;

    // Grant selection: lone requester wins, a tie goes to whoever did not win last.
    always_comb begin
        grant_s = REQ_ID_1;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ~last_grant_q;
        end else if (bus.req0_valid) begin
            grant_s = REQ_ID_0;
        end else begin
            grant_s = REQ_ID_1;
        end
    end

    // Next-state, capture and response logic for the IDLE/EVAL/RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        f3_d         = f3_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        ready0_s     = 1'b0;
        ready1_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!reset && any_valid_s) begin
                    ready0_s     = (grant_s == REQ_ID_0);
                    ready1_s     = (grant_s == REQ_ID_1);
                    last_grant_d = grant_s;
                    id_d         = grant_s;
                    if (grant_s == REQ_ID_1) begin
                        a_d  = bus.req1_a;
                        b_d  = bus.req1_b;
                        f3_d = bus.req1_funct3;
                    end else begin
                        a_d  = bus.req0_a;
                        b_d  = bus.req0_b;
                        f3_d = bus.req0_funct3;
                    end
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL: begin
                rsp_valid_d  = 1'b1;
                rsp_id_d     = id_q;
                rsp_result_d = cond_eval(f3_q, eq_s, lt_s, ltu_s);
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State, captured operands and response registers; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            f3_q         <= 3'b000;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            f3_q         <= f3_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed self-checking bench for cmp_arbiter.
module tb_cmp_arbiter;
    import cmp_arbiter_pkg::*;

    localparam int W = 64;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    cmp_arbiter_if #(.WORDSIZE(W)) bus ();

    cmp_arbiter #(.WORDSIZE(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] f3);
        if (id == 1'b0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_funct3 = f3;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_funct3 = f3;
        end
    endtask

    // Issue one request from IDLE and follow it to the first RESP cycle.
    task automatic send(input logic id, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] f3, input logic exp);
        set_req(id, a, b, f3);
        #1;
        chk("accept_rdy0", {63'd0, bus.req0_ready}, {63'd0, id == 1'b0});
        chk("accept_rdy1", {63'd0, bus.req1_ready}, {63'd0, id == 1'b1});
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("eval_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("eval_rdy", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
        cyc();
        chk("resp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        chk("resp_id", {63'd0, bus.rsp_id}, {63'd0, id});
        chk("resp_result", {63'd0, bus.rsp_result}, {63'd0, exp});
    endtask

    task automatic drain();
        bus.rsp_ready = 1'b1;
        cyc();
        chk("drain_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    endtask

    initial begin
        logic [7:0]  sweep_exp;
        logic [63:0] all_ones;
        n_checks = 0;
        n_errors = 0;
        sweep_exp = 8'b1001_0110;
        all_ones  = '1;

        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 64'd0; bus.req0_b = 64'd0; bus.req0_funct3 = 3'b000;
        bus.req1_valid = 1'b1; bus.req1_a = 64'd0; bus.req1_b = 64'd0; bus.req1_funct3 = 3'b000;
        cyc();
        cyc();
        chk("rst_rdy", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_rsp_id", {63'd0, bus.rsp_id}, 64'd0);
        chk("rst_rsp_result", {63'd0, bus.rsp_result}, 64'd0);
        reset = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        send(1'b0, 64'd5, 64'd5, BEQ, 1'b1);
        drain();

        send(1'b1, 64'h8000_0000_0000_0000, 64'd1, SLT, 1'b1);
        drain();
        send(1'b1, 64'h8000_0000_0000_0000, 64'd1, SLTU, 1'b0);
        drain();
        send(1'b1, all_ones, all_ones, BGEU, 1'b1);
        drain();

        // Both requesters valid continuously: grants alternate, one accept per 3 cycles.
        set_req(1'b0, 64'd3, 64'd3, BEQ);
        set_req(1'b1, 64'd2, 64'd1, SLTU);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("alt_rdy0", {63'd0, bus.req0_ready}, {63'd0, (k % 2) == 0});
            chk("alt_rdy1", {63'd0, bus.req1_ready}, {63'd0, (k % 2) == 1});
            cyc();
            chk("alt_eval_rdy", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
            chk("alt_eval_valid", {63'd0, bus.rsp_valid}, 64'd0);
            cyc();
            chk("alt_resp_valid", {63'd0, bus.rsp_valid}, 64'd1);
            chk("alt_resp_rdy", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
            chk("alt_resp_id", {63'd0, bus.rsp_id}, (k % 2) == 1 ? 64'd1 : 64'd0);
            chk("alt_resp_result", {63'd0, bus.rsp_result}, (k % 2) == 1 ? 64'd0 : 64'd1);
            cyc();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Consumer stalls the response for 5 cycles.
        bus.rsp_ready = 1'b0;
        send(1'b0, 64'd7, 64'd9, BNE, 1'b1);
        set_req(1'b0, 64'd7, 64'd9, BNE);
        set_req(1'b1, 64'd1, 64'd1, SLT);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", {63'd0, bus.rsp_valid}, 64'd1);
            chk("stall_id", {63'd0, bus.rsp_id}, 64'd0);
            chk("stall_result", {63'd0, bus.rsp_result}, 64'd1);
            chk("stall_rdy", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
            cyc();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain();
        send(1'b1, all_ones, 64'd1, SLT, 1'b1);
        drain();

        // Reset during EVAL discards the result and restores the req0 tie preference.
        set_req(1'b0, 64'd1, 64'd2, BNE);
        #1;
        chk("rsteval_accept", {63'd0, bus.req0_ready}, 64'd1);
        cyc();
        bus.req0_valid = 1'b0;
        reset = 1'b1;
        cyc();
        chk("rsteval_valid", {63'd0, bus.rsp_valid}, 64'd0);
        set_req(1'b0, 64'd1, 64'd2, BNE);
        set_req(1'b1, 64'd4, 64'd4, BEQ);
        #1;
        chk("rsteval_rdy_in_rst", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
        cyc();
        chk("rsteval_valid2", {63'd0, bus.rsp_valid}, 64'd0);
        reset = 1'b0;
        #1;
        chk("rsteval_tie_rdy", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd1);
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        cyc();
        chk("rsteval_resp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        chk("rsteval_resp_id", {63'd0, bus.rsp_id}, 64'd0);
        chk("rsteval_resp_result", {63'd0, bus.rsp_result}, 64'd1);
        drain();

        // All eight condition codes with a = -1, b = 1.
        for (int f = 0; f < 8; f++) begin
            send(1'b0, all_ones, 64'd1, f[2:0], sweep_exp[f]);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
